// File: rtl/bcd_time_counter.sv
// Four-digit BCD time counter (mil:cen / dec:uni) with an integrated tick divider,
// configurable pair moduli, up/down count, range-checked preset and countdown expiry.
module bcd_time_counter #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned MAX_HI   = 59,
    parameter int unsigned MAX_LO   = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       dir,
    input  logic       load,
    input  logic [7:0] load_hi,
    input  logic [7:0] load_lo,
    output logic [3:0] mil,
    output logic [3:0] cen,
    output logic [3:0] dec,
    output logic [3:0] uni,
    output logic       tick,
    output logic       wrap,
    output logic       done,
    output logic       load_err
);

    localparam int unsigned DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [7:0]       MAX_HI_BCD = {4'(MAX_HI / 10), 4'(MAX_HI % 10)};
    localparam logic [7:0]       MAX_LO_BCD = {4'(MAX_LO / 10), 4'(MAX_LO % 10)};

    typedef enum logic [1:0] {
        STOP    = 2'd0,
        COUNT   = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       hi_q, hi_d;
    logic [7:0]       lo_q, lo_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [7:0] up_hi, up_lo, dn_hi, dn_lo;
    logic       up_carry, up_wrap, dn_borrow, at_zero, load_ok;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Candidate next digits for an up or down step
    always_comb begin
        up_carry  = (lo_q == MAX_LO_BCD);
        up_wrap   = up_carry && (hi_q == MAX_HI_BCD);
        up_lo     = up_carry ? 8'h00 : bcd_inc(lo_q);
        up_hi     = !up_carry ? hi_q : (up_wrap ? 8'h00 : bcd_inc(hi_q));
        dn_borrow = (lo_q == 8'h00);
        dn_lo     = dn_borrow ? MAX_LO_BCD : bcd_dec(lo_q);
        dn_hi     = dn_borrow ? bcd_dec(hi_q) : hi_q;
        at_zero   = (hi_q == 8'h00) && (lo_q == 8'h00);
        load_ok   = bcd_ok(load_hi) && bcd_ok(load_lo) &&
                    (load_hi <= MAX_HI_BCD) && (load_lo <= MAX_LO_BCD);
    end

    // Next-state logic: load beats a due step; a rejected load freezes the cycle
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        done_d  = done_q;
        err_d   = 1'b0;

        if (load) begin
            if (load_ok) begin
                hi_d    = load_hi;
                lo_d    = load_lo;
                div_d   = '0;
                done_d  = 1'b0;
                state_d = STOP;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                STOP, COUNT: begin
                    // The divider also advances on the edge entering COUNT, so the
                    // first tick lands TICK_DIV cycles after run rises.
                    if (!run) begin
                        state_d = STOP;
                    end else begin
                        state_d = COUNT;
                        if (div_q == DIV_LAST) begin
                            div_d = '0;
                            if (!dir) begin
                                hi_d   = up_hi;
                                lo_d   = up_lo;
                                tick_d = 1'b1;
                                wrap_d = up_wrap;
                            end else if (at_zero) begin
                                state_d = EXPIRED;
                                done_d  = 1'b1;
                            end else begin
                                hi_d   = dn_hi;
                                lo_d   = dn_lo;
                                tick_d = 1'b1;
                                if ((dn_hi == 8'h00) && (dn_lo == 8'h00)) begin
                                    state_d = EXPIRED;
                                    done_d  = 1'b1;
                                end
                            end
                        end else begin
                            div_d = div_q + DIV_W'(1);
                        end
                    end
                end
                EXPIRED: begin
                    if (!dir) begin
                        state_d = STOP;
                        done_d  = 1'b0;
                    end
                end
                default: state_d = STOP;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STOP;
            div_q   <= '0;
            hi_q    <= 8'h00;
            lo_q    <= 8'h00;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mil      = hi_q[7:4];
    assign cen      = hi_q[3:0];
    assign dec      = lo_q[7:4];
    assign uni      = lo_q[3:0];
    assign tick     = tick_q;
    assign wrap     = wrap_q;
    assign done     = done_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench: two counters (59/59 and 23/59, TICK_DIV=4) share one stimulus
// stream; inputs change and outputs are sampled on the falling edge.
module tb_bcd_time_counter;

    logic       clk = 1'b0;
    logic       reset, run, dir, load;
    logic [7:0] load_hi, load_lo;

    logic [3:0] m59, c59, d59, n59, m23, c23, d23, n23;
    logic       tk59, wr59, dn59, er59, tk23, wr23, dn23, er23;
    logic [15:0] dg59, dg23;

    int vectors = 0;
    int miscompares = 0;

    assign dg59 = {m59, c59, d59, n59};
    assign dg23 = {m23, c23, d23, n23};

    always #5 clk = ~clk;

    bcd_time_counter #(.TICK_DIV(4), .MAX_HI(59), .MAX_LO(59)) u59 (
        .clk(clk), .reset(reset), .run(run), .dir(dir), .load(load),
        .load_hi(load_hi), .load_lo(load_lo),
        .mil(m59), .cen(c59), .dec(d59), .uni(n59),
        .tick(tk59), .wrap(wr59), .done(dn59), .load_err(er59)
    );

    bcd_time_counter #(.TICK_DIV(4), .MAX_HI(23), .MAX_LO(59)) u23 (
        .clk(clk), .reset(reset), .run(run), .dir(dir), .load(load),
        .load_hi(load_hi), .load_lo(load_lo),
        .mil(m23), .cen(c23), .dec(d23), .uni(n23),
        .tick(tk23), .wrap(wr23), .done(dn23), .load_err(er23)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // One-cycle preset strobe; returns on the falling edge after the load edge
    task automatic do_load(input logic [7:0] h, input logic [7:0] l);
        load = 1'b1; load_hi = h; load_lo = l;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1; run = 1'b0; dir = 1'b0; load = 1'b0;
        load_hi = 8'h00; load_lo = 8'h00;
        cyc(2);
        chk ("rst_dig59", dg59, 16'h0000);
        chk ("rst_dig23", dg23, 16'h0000);
        chkb("rst_tick",  tk59, 1'b0);
        chkb("rst_wrap",  wr59, 1'b0);
        chkb("rst_done",  dn59, 1'b0);
        chkb("rst_err",   er59, 1'b0);

        // Up count from reset: ticks every 4 cycles
        reset = 1'b0; run = 1'b1;
        cyc(3); chkb("up_early_tick", tk59, 1'b0);
        cyc(1); chk ("up_0001", dg59, 16'h0001); chkb("up_tick1", tk59, 1'b1); chkb("up_wrap1", wr59, 1'b0);
        cyc(4); chk ("up_0002", dg59, 16'h0002); chkb("up_tick2", tk59, 1'b1);
        cyc(4); chk ("up_0003", dg59, 16'h0003); chkb("up_tick3", tk59, 1'b1);
        cyc(1); chkb("tick_width", tk59, 1'b0);

        // Full rollover and carries
        do_load(8'h59, 8'h59);
        chk ("ld_5959", dg59, 16'h5959); chkb("ld_no_err", er59, 1'b0);
        chkb("ld_hi_over23", er23, 1'b1); chkb("ld_no_tick", tk59, 1'b0);
        cyc(4); chk("wrap_0000", dg59, 16'h0000); chkb("wrap_tick", tk59, 1'b1); chkb("wrap_pulse", wr59, 1'b1);
        do_load(8'h12, 8'h09); cyc(4); chk("up_1210", dg59, 16'h1210); chkb("up_1210_wrap", wr59, 1'b0);
        do_load(8'h00, 8'h59); cyc(4); chk("up_0100", dg59, 16'h0100);

        // Down count with borrows
        dir = 1'b1;
        do_load(8'h12, 8'h00); cyc(4); chk("dn_1159", dg59, 16'h1159); chkb("dn_tick", tk59, 1'b1);
        do_load(8'h01, 8'h00); cyc(4); chk("dn_0059", dg59, 16'h0059);

        // Countdown expiry
        do_load(8'h00, 8'h02);
        cyc(4); chk("cd_0001", dg59, 16'h0001); chkb("cd_done0", dn59, 1'b0);
        cyc(4); chk("cd_0000", dg59, 16'h0000); chkb("cd_tick", tk59, 1'b1); chkb("cd_done1", dn59, 1'b1);
        for (int i = 0; i < 12; i++) begin
            cyc(1); chkb("exp_no_tick", tk59, 1'b0);
        end
        chk("exp_hold", dg59, 16'h0000); chkb("exp_done_hold", dn59, 1'b1);
        do_load(8'h00, 8'h05); chkb("reload_done0", dn59, 1'b0); chk("reload_0005", dg59, 16'h0005);
        cyc(4); chk("reload_0004", dg59, 16'h0004); chkb("reload_tick", tk59, 1'b1);

        // Down step from 00:00 expires without a tick; dir=0 releases it
        do_load(8'h00, 8'h00);
        cyc(4); chkb("zero_no_tick", tk59, 1'b0); chkb("zero_done", dn59, 1'b1); chk("zero_dig", dg59, 16'h0000);
        dir = 1'b0;
        cyc(1); chkb("dir_clears_done", dn59, 1'b0);
        cyc(4); chk("dir_up_0001", dg59, 16'h0001); chkb("dir_up_tick", tk59, 1'b1);

        // 23/59 modulus wraps at 23:59
        reset = 1'b1; cyc(2); reset = 1'b0;
        do_load(8'h23, 8'h59);
        cyc(4);
        chk ("h23_wrap_dig", dg23, 16'h0000); chkb("h23_wrap", wr23, 1'b1); chkb("h23_tick", tk23, 1'b1);
        chk ("h59_2400", dg59, 16'h2400);    chkb("h59_no_wrap", wr59, 1'b0);

        // Rejected presets
        run = 1'b0; cyc(2);
        do_load(8'h00, 8'h6A);
        chkb("rej_6A_err59", er59, 1'b1); chkb("rej_6A_err23", er23, 1'b1);
        chk ("rej_6A_dig59", dg59, 16'h2400); chk("rej_6A_dig23", dg23, 16'h0000);
        cyc(1); chkb("rej_err_width", er59, 1'b0);
        do_load(8'h00, 8'h60);
        chkb("rej_60_err", er59, 1'b1); chk("rej_60_dig", dg59, 16'h2400);
        do_load(8'h24, 8'h10);
        chkb("rej_24_err23", er23, 1'b1); chk("rej_24_dig23", dg23, 16'h0000);
        chkb("acc_24_err59", er59, 1'b0); chk("acc_24_dig59", dg59, 16'h2410);

        // Reset on the step edge
        run = 1'b1;
        do_load(8'h00, 8'h30);
        cyc(3); reset = 1'b1;
        cyc(1);
        chk("rst_step_dig", dg59, 16'h0000); chkb("rst_step_tick", tk59, 1'b0); chkb("rst_step_wrap", wr59, 1'b0);

        // Pause at div_cnt=2, resume: tick two cycles later
        reset = 1'b0;
        cyc(2); run = 1'b0;
        cyc(3); chkb("pause_no_tick", tk59, 1'b0); chk("pause_dig", dg59, 16'h0000);
        run = 1'b1;
        cyc(1); chkb("resume_early", tk59, 1'b0);
        cyc(1); chkb("resume_tick", tk59, 1'b1); chk("resume_0001", dg59, 16'h0001);

        // Load on a step edge wins, no tick
        cyc(3);
        do_load(8'h45, 8'h45);
        chk("ldstep_dig", dg59, 16'h4545); chkb("ldstep_no_tick", tk59, 1'b0);
        cyc(4); chk("ldstep_next", dg59, 16'h4546); chkb("ldstep_tick", tk59, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
